// File: rtl/seg7_scanner_pkg.sv
// Shared definitions for 7-segment display blocks: active-low glyphs, digit-off pattern, scan states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_scanner_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] DIG_OFF = 4'hF;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_scanner_hex_to_seg7.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg7
    import seg7_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_OFF;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit common-anode 7-segment scanner with per-frame input snapshot and blanking gaps.
// Latency: digit lit BLANK_CYC cycles after its slot starts; inputs visible within 1 frame + BLANK_CYC + 1.
// Backpressure: none; inputs are sampled once per frame and ignored otherwise.
module seg7_scanner
    import seg7_scanner_pkg::*;
#(
    parameter int SCAN_DIV  = 4096,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digit_data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  dig_n
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;

    logic [15:0]      snap_data_q;
    logic [3:0]       snap_dp_q;
    logic [3:0]       snap_blank_q;

    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       dig_q, dig_d;

    logic             snap_en;
    logic [15:0]      cur_data;
    logic [3:0]       cur_dp;
    logic [3:0]       cur_blank;
    logic [3:0]       cur_nib;
    logic [6:0]       hex_seg;

    assign snap_en = (state_q == S_BLANK) && (idx_q == 2'd0) && (cnt_q == '0);

    // Bypass the snapshot on the capture edge so BLANK_CYC=1 still shows this frame's values.
    assign cur_data  = snap_en ? digit_data : snap_data_q;
    assign cur_dp    = snap_en ? dp_in      : snap_dp_q;
    assign cur_blank = snap_en ? blank_in   : snap_blank_q;
    assign cur_nib   = cur_data[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble (cur_nib),
        .seg_n  (hex_seg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        dig_d   = dig_q;
        case (state_q)
            S_BLANK: begin
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
                dig_d = DIG_OFF;
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                    seg_d   = hex_seg;
                    dp_d    = ~cur_dp[idx_q];
                    dig_d   = cur_blank[idx_q] ? DIG_OFF : ~(4'b0001 << idx_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRIVE: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    seg_d   = SEG_OFF;
                    dp_d    = 1'b1;
                    dig_d   = DIG_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
                idx_d   = 2'd0;
                seg_d   = SEG_OFF;
                dp_d    = 1'b1;
                dig_d   = DIG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            dig_q   <= DIG_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            dig_q   <= dig_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_data_q  <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
        end else if (snap_en) begin
            snap_data_q  <= digit_data;
            snap_dp_q    <= dp_in;
            snap_blank_q <= blank_in;
        end
    end

    assign seg_n = seg_q;
    assign dp_n  = dp_q;
    assign dig_n = dig_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner: a frame/slot arithmetic model predicts every output cycle,
// plus independent checks on digit exclusivity, dark gaps and lit slot length.
module tb_seg7_scanner;

    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        reset;
    logic [15:0] digit_data;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_n;

    int errors = 0;
    int checks = 0;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          next_j;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;

    int          dark_run;
    int          lit_run;
    bit          seen_lit;
    logic [3:0]  prev_dig;

    seg7_scanner #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_data (digit_data),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .dig_n      (dig_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge: predict outputs from the inputs present at the edge, then compare.
    task automatic tick();
        logic        r;
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
        int          j;
        int          m;
        int          dg;
        logic [3:0]  e_dig;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  nib;
        r = reset;
        d = digit_data;
        p = dp_in;
        b = blank_in;
        @(posedge clk);
        #1;
        e_dig = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (r) begin
            next_j   = 0;
            m_data   = '0;
            m_dp     = '0;
            m_blank  = '0;
            seen_lit = 1'b0;
            dark_run = 0;
            lit_run  = 0;
        end else begin
            j = next_j;
            next_j++;
            if (j % FRAME == 0) begin
                m_data  = d;
                m_dp    = p;
                m_blank = b;
            end
            m = j % SLOT;
            if (m >= BC - 1 && m < BC - 1 + SD) begin
                dg    = (j / SLOT) % 4;
                nib   = m_data[dg*4 +: 4];
                e_seg = hex_tbl[nib];
                e_dp  = ~m_dp[dg];
                e_dig = m_blank[dg] ? 4'hF : ~(4'b0001 << dg);
            end
        end
        chk("dig_n", 32'(dig_n), 32'(e_dig));
        chk("seg_n", 32'(seg_n), 32'(e_seg));
        chk("dp_n",  32'(dp_n),  32'(e_dp));
        chk("one_low", 32'($countones(~dig_n) <= 1), 32'd1);
        if (!r) begin
            if (dig_n != 4'hF) begin
                if (lit_run == 0 && seen_lit)
                    chk("dark_gap", 32'(dark_run >= BC), 32'd1);
                if (lit_run > 0)
                    chk("same_digit", 32'(dig_n), 32'(prev_dig));
                lit_run++;
                dark_run = 0;
                seen_lit = 1'b1;
                prev_dig = dig_n;
            end else begin
                if (lit_run > 0)
                    chk("lit_len", 32'(lit_run), 32'(SD));
                lit_run = 0;
                dark_run++;
            end
        end
    endtask

    task automatic wait_frame();
        while (next_j % FRAME != 0) tick();
    endtask

    initial begin
        reset      = 1'b1;
        digit_data = 16'h4321;
        dp_in      = 4'h0;
        blank_in   = 4'h0;
        next_j     = 0;
        dark_run   = 0;
        lit_run    = 0;
        seen_lit   = 1'b0;
        prev_dig   = 4'hF;

        repeat (3) tick();
        chk("rst_dig", 32'(dig_n), 32'hF);
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp",  32'(dp_n),  32'h1);

        // Basic scan of 4321
        reset = 1'b0;
        tick();
        chk("t1_first_dark", 32'(dig_n), 32'hF);
        tick();
        chk("t1_dig0", 32'(dig_n), 32'hE);
        chk("t1_seg0", 32'(seg_n), 32'h79);
        repeat (2 * FRAME - 2) tick();

        // FEDC with decimal point on digit 1
        digit_data = 16'hFEDC;
        dp_in      = 4'b0010;
        repeat (3 * FRAME) tick();

        // Mid-frame input change must wait for the next snapshot
        dp_in = 4'h0;
        wait_frame();
        digit_data = 16'h0000;
        repeat (10) tick();
        digit_data = 16'h8888;
        repeat (2 * FRAME) tick();

        // Blanked digits 0 and 2
        blank_in = 4'b0101;
        repeat (3 * FRAME) tick();
        blank_in = 4'h0;

        // Reset during digit 2's drive slot
        wait_frame();
        repeat (2 * SLOT + BC) tick();
        chk("t5_pre_lit", 32'(dig_n), 32'hB);
        reset = 1'b1;
        tick();
        chk("t5_rst_dig", 32'(dig_n), 32'hF);
        chk("t5_rst_seg", 32'(seg_n), 32'h7F);
        tick();
        reset      = 1'b0;
        digit_data = 16'h5A96;
        repeat (2 * FRAME) tick();

        // Random traffic with occasional resets
        for (int f = 0; f < 1000; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 7) == 0) digit_data = 16'($urandom);
                if ($urandom_range(0, 7) == 0) dp_in      = 4'($urandom);
                if ($urandom_range(0, 15) == 0) blank_in  = 4'($urandom);
                reset = ($urandom_range(0, 2999) == 0);
                tick();
            end
        end
        reset = 1'b0;
        repeat (FRAME) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
